// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter in front of a single SRAM port
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    parameter int TIMEOUT    = 16,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [AW-1:0]         addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [BW-1:0]         be0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic                  err0_o,

    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [AW-1:0]         addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic [BW-1:0]         be1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  err1_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BW-1:0]         mem_be_o,
    output logic                  mem_rready_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  win;
    logic                  done;
    logic                  done_err;
    logic [DATA_WIDTH-1:0] done_data;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        win       = 1'b0;
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;

        case (state_q)
            IDLE: begin
                // No grant while a completion is being presented, so grants are
                // spaced at least four cycles apart and the pointer is settled.
                if (rst_ni && !(rvalid0_q || rvalid1_q) && (req0_i || req1_i)) begin
                    win     = (req0_i && req1_i) ? ptr_q : req1_i;
                    gnt0_o  = !win;
                    gnt1_o  = win;
                    owner_d = win;
                    we_d    = win ? we1_i    : we0_i;
                    addr_d  = win ? addr1_i  : addr0_i;
                    wdata_d = win ? wdata1_i : wdata0_i;
                    be_d    = win ? be1_i    : be0_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (mem_rvalid_i) begin
                    done      = 1'b1;
                    done_data = mem_rdata_i;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    done_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = !owner_q;
            if (owner_q) begin
                rvalid1_d = 1'b1;
                err1_d    = done_err;
                rdata1_d  = done_data;
            end else begin
                rvalid0_d = 1'b1;
                err0_d    = done_err;
                rdata0_d  = done_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign mem_req_o    = (state_q == ISSUE);
    assign mem_rready_o = (state_q == WAIT_RSP);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign err0_o    = err0_q;
    assign err1_o    = err1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with a behavioural SRAM
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [9:0]  addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [3:0]  be0_i, be1_i;
    logic        gnt0_o, rvalid0_o, err0_o, gnt1_o, rvalid1_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic        mem_req_o, mem_we_o, mem_rready_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    sram_port_arbiter #(.DATA_WIDTH(32), .NUM_WORDS(1024), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i), .be0_i(be0_i),
        .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o), .err0_o(err0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i), .be1_i(be1_i),
        .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o), .err1_o(err1_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rready_o(mem_rready_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct packed {
        logic        err;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem[0:1023];
    logic [31:0] ref_mem[0:1023];
    int          gnt_wait = 0;
    int          rsp_wait = 0;
    bit          rsp_en = 1'b1;
    logic [31:0] rd_pend = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rv_cyc0 = 0;
    int          last_gcyc = 0;
    int          g_port[8];
    int          g_cyc[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic sram_model();
        int gnt_cnt = 0;
        int rsp_cnt = 0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (mem_req_o) begin
                if (gnt_cnt < gnt_wait) begin
                    gnt_cnt++;
                end else begin
                    mem_gnt_i = 1'b1;
                    gnt_cnt   = 0;
                    if (mem_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                        rd_pend = 32'hBAD0BAD0;
                    end else begin
                        rd_pend = mem[mem_addr_o];
                    end
                end
            end else begin
                gnt_cnt = 0;
            end
            if (mem_rready_o && rsp_en) begin
                if (rsp_cnt == rsp_wait) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rd_pend;
                end
                rsp_cnt++;
            end else begin
                rsp_cnt = 0;
            end
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic [31:0] p0 = '0;
        logic [31:0] p1 = '0;
        forever begin
            @(negedge clk);
            if (rvalid0_o) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp0_unexpected got rvalid0=1 exp no response");
                end else begin
                    e = q0.pop_front();
                    rv_cyc0 = cyc;
                    if (err0_o !== e.err || (!e.wr && rdata0_o !== e.data)) begin
                        n_fail++;
                        $display("FAIL rsp0 got err=%b data=%h exp err=%b data=%h", err0_o, rdata0_o, e.err, e.data);
                    end
                end
                n_checks++;
                if (rvalid1_o !== 1'b0 || rdata1_o !== p1) begin
                    n_fail++;
                    $display("FAIL port1_hold got rvalid1=%b rdata1=%h exp 0 %h", rvalid1_o, rdata1_o, p1);
                end
            end
            if (rvalid1_o) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp1_unexpected got rvalid1=1 exp no response");
                end else begin
                    e = q1.pop_front();
                    if (err1_o !== e.err || (!e.wr && rdata1_o !== e.data)) begin
                        n_fail++;
                        $display("FAIL rsp1 got err=%b data=%h exp err=%b data=%h", err1_o, rdata1_o, e.err, e.data);
                    end
                end
                n_checks++;
                if (rdata0_o !== p0) begin
                    n_fail++;
                    $display("FAIL port0_hold got rdata0=%h exp %h", rdata0_o, p0);
                end
            end
            p0 = rdata0_o;
            p1 = rdata1_o;
        end
    endtask

    task automatic push_exp(input bit port, input bit we, input logic [9:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input bit err);
        exp_t e;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
            e = {1'b0, 1'b1, 32'h0};
        end else begin
            e = {err, 1'b0, err ? 32'h0 : ref_mem[addr]};
        end
        if (port) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the grant.
    task automatic issue(input bit port, input bit we, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input bit push, input bit err);
        bit granted = 1'b0;
        if (port) begin
            req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata; be1_i = be;
        end else begin
            req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata; be0_i = be;
        end
        for (int i = 0; i < 50 && !granted; i++) begin
            #2;
            if (port ? gnt1_o : gnt0_o) begin
                granted   = 1'b1;
                last_gcyc = cyc;
                if (push) push_exp(port, we, addr, wdata, be, err);
            end
            @(negedge clk);
        end
        req0_i = 1'b0;
        req1_i = 1'b0;
        if (!granted) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_grant got no grant on port %0d exp grant within 50 cycles", port);
        end
    endtask

    task automatic dual(input int n, input bit err0_first);
        int k = 0;
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 10'h030; wdata0_i = '0; be0_i = '0;
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 10'h031; wdata1_i = '0; be1_i = '0;
        for (int i = 0; i < 200 && k < n; i++) begin
            #2;
            if (gnt0_o || gnt1_o) begin
                n_checks++;
                if (gnt0_o && gnt1_o) begin
                    n_fail++;
                    $display("FAIL dual_gnt got gnt0=1 gnt1=1 exp one grant");
                end
                g_port[k] = gnt1_o ? 1 : 0;
                g_cyc[k]  = cyc;
                if (gnt1_o) begin
                    push_exp(1'b1, 1'b0, 10'h031, '0, '0, 1'b0);
                    rsp_en = 1'b1;
                end else begin
                    push_exp(1'b0, 1'b0, 10'h030, '0, '0, err0_first && k == 0);
                end
                k++;
            end
            @(negedge clk);
        end
        req0_i = 1'b0;
        req1_i = 1'b0;
        n_checks++;
        if (k != n) begin
            n_fail++;
            $display("FAIL dual_count got %0d grants exp %0d", k, n);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d/%0d pending responses exp 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        req0_i = 1'b0;
        req1_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        req0_i = 1'b1;
        req1_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if ({gnt0_o, gnt1_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt got %b exp 00", {gnt0_o, gnt1_o});
        end
        n_checks++;
        if ({rvalid0_o, rvalid1_o, err0_o, err1_o, rdata0_o, rdata1_o, mem_req_o, mem_we_o,
             mem_addr_o, mem_wdata_o, mem_be_o, mem_rready_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got nonzero exp all zero");
        end
        @(negedge clk);
        req0_i = 1'b0;
        req1_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, mem_rready_o, rvalid0_o, rvalid1_o, mem_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_release got nonzero exp idle zeros");
        end
    endtask

    task automatic test_single_read();
        mem[10'h010]     = 32'hDEADBEEF;
        ref_mem[10'h010] = 32'hDEADBEEF;
        issue(1'b0, 1'b0, 10'h010, '0, 4'hF, 1'b1, 1'b0);
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 10'h010}) begin
            n_fail++;
            $display("FAIL read_issue got req=%b we=%b addr=%h exp 1 0 010", mem_req_o, mem_we_o, mem_addr_o);
        end
        wait_drain();
        n_checks++;
        if (rv_cyc0 - last_gcyc != 3) begin
            n_fail++;
            $display("FAIL read_latency got %0d exp 3", rv_cyc0 - last_gcyc);
        end
    endtask

    task automatic test_write();
        int n_iss = 0;
        bit stop = 1'b0;
        mem[10'h020]     = 32'h11223344;
        ref_mem[10'h020] = 32'h11223344;
        gnt_wait = 5;
        issue(1'b1, 1'b1, 10'h020, 32'hA5A5A5A5, 4'b0011, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !stop; i++) begin
            if (mem_req_o) begin
                n_checks++;
                if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'b0011, 10'h020, 32'hA5A5A5A5}) begin
                    n_fail++;
                    $display("FAIL write_issue_stable got we=%b be=%b addr=%h wdata=%h exp 1 0011 020 a5a5a5a5",
                             mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
                end
                n_iss++;
                @(negedge clk);
            end else begin
                stop = 1'b1;
            end
        end
        n_checks++;
        if (n_iss != 6) begin
            n_fail++;
            $display("FAIL write_issue_cycles got %0d exp 6", n_iss);
        end
        n_checks++;
        if ({mem_req_o, mem_rready_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b0, 1'b1, 1'b1, 4'b0011, 10'h020}) begin
            n_fail++;
            $display("FAIL write_wait_hold got req=%b rready=%b we=%b be=%b addr=%h exp 0 1 1 0011 020",
                     mem_req_o, mem_rready_o, mem_we_o, mem_be_o, mem_addr_o);
        end
        gnt_wait = 0;
        wait_drain();
        issue(1'b1, 1'b0, 10'h020, '0, 4'hF, 1'b1, 1'b0);
        wait_drain();
        n_checks++;
        if (rdata1_o !== 32'h1122A5A5) begin
            n_fail++;
            $display("FAIL write_readback got %h exp 1122a5a5", rdata1_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        dual(4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (g_port[k] != k % 2) begin
                n_fail++;
                $display("FAIL rr_order grant %0d got port %0d exp %0d", k, g_port[k], k % 2);
            end
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (g_cyc[k] - g_cyc[k-1] < 4) begin
                n_fail++;
                $display("FAIL rr_spacing grant %0d got %0d cycles exp >=4", k, g_cyc[k] - g_cyc[k-1]);
            end
        end
        wait_drain();
    endtask

    task automatic test_timeout();
        do_reset();
        rsp_en = 1'b0;
        dual(2, 1'b1);
        n_checks++;
        if (g_port[0] != 0 || g_port[1] != 1) begin
            n_fail++;
            $display("FAIL timeout_order got %0d,%0d exp 0,1", g_port[0], g_port[1]);
        end
        wait_drain();
        n_checks++;
        if (rv_cyc0 - g_cyc[0] != 6) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d exp 6", rv_cyc0 - g_cyc[0]);
        end
    endtask

    task automatic test_timeout_tie();
        rsp_wait = 3;
        issue(1'b0, 1'b0, 10'h050, '0, 4'hF, 1'b1, 1'b0);
        wait_drain();
        n_checks++;
        if (rv_cyc0 - last_gcyc != 6) begin
            n_fail++;
            $display("FAIL tie_latency got %0d exp 6", rv_cyc0 - last_gcyc);
        end
        rsp_wait = 0;
    endtask

    task automatic test_reset_mid();
        int rel_cyc;
        rsp_en = 1'b0;
        issue(1'b0, 1'b0, 10'h040, '0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !mem_rready_o; i++) @(negedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o, rdata0_o, rdata1_o, mem_req_o,
             mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_rready_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got nonzero (rready=%b addr=%h) exp all zero", mem_rready_o, mem_addr_o);
        end
        @(negedge clk);
        rst_ni  = 1'b1;
        rsp_en  = 1'b1;
        rel_cyc = cyc;
        issue(1'b0, 1'b0, 10'h040, '0, 4'hF, 1'b1, 1'b0);
        n_checks++;
        if (last_gcyc != rel_cyc) begin
            n_fail++;
            $display("FAIL midreset_idle got grant at +%0d exp +0", last_gcyc - rel_cyc);
        end
        wait_drain();
        n_checks++;
        if (rv_cyc0 - last_gcyc != 3) begin
            n_fail++;
            $display("FAIL midreset_latency got %0d exp 3", rv_cyc0 - last_gcyc);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b0;
        req0_i = 1'b0; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0; be0_i = '0;
        req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0; be1_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = (i * 32'h01010101) ^ 32'h5A5A0000;
            ref_mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
        end
        fork
            cycle_counter();
            sram_model();
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_timeout_tie();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the data width of both requester ports and the SRAM port.
REQ-002 The block SHALL have parameter NUM_WORDS, default 1024, the SRAM depth; AW = $clog2(NUM_WORDS).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum number of WAIT_RSP cycles before an error completion (legal range 2..255).
REQ-004 The block SHALL have the following ports:
  clk_i  in  1  single clock; rising edge.
  rst_ni  in  1  reset; asynchronous, active-low.
  reqN_i (N=0,1)  in  1  requester N transaction request.
  weN_i  in  1  requester N write (1) / read (0).
  addrN_i  in  AW  requester N word address.
  wdataN_i  in  DATA_WIDTH  requester N write data.
  beN_i  in  DATA_WIDTH/8  requester N byte enables.
  gntN_o  out  1  request accepted, 1-cycle pulse.
  rvalidN_o  out  1  response valid, 1-cycle pulse.
  rdataN_o  out  DATA_WIDTH  response data.
  errN_o  out  1  response is a timeout error; qualified by rvalidN_o.
  mem_req_o, mem_we_o  out  1 each  SRAM request / write.
  mem_addr_o  out  AW  SRAM address.
  mem_wdata_o  out  DATA_WIDTH  SRAM write data.
  mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
  mem_rready_o  out  1  arbiter ready for the SRAM response.
  mem_gnt_i, mem_rvalid_i  in  1 each  SRAM grant / response valid.
  mem_rdata_i  in  DATA_WIDTH  SRAM read data.

Function
REQ-005 The block SHALL implement FSM states IDLE, ISSUE and WAIT_RSP, with at most one transaction outstanding.
REQ-006 IDLE: if any reqN_i=1, the block SHALL assert the winner's gntN_o combinationally in that cycle, capture we/addr/wdata/be and the owner ID into registers, and go to ISSUE next cycle.
REQ-007 Arbitration SHALL be round-robin with a 1-bit priority pointer: a sole requester always wins; when both request, the port named by the pointer wins.
REQ-008 After every completion (data or error), the pointer SHALL be set to the port that did not own the completed transaction.
REQ-009 ISSUE: mem_req_o SHALL be 1 and mem_we_o/addr/wdata/be SHALL be driven from the captured registers; on mem_gnt_i=1 the FSM SHALL go to WAIT_RSP, otherwise remain in ISSUE with all fields stable.
REQ-010 In IDLE and WAIT_RSP, mem_req_o SHALL be 0; mem_addr_o/wdata/be/we SHALL hold their captured values.
REQ-011 WAIT_RSP: mem_rready_o SHALL be 1; on mem_rvalid_i=1 the block SHALL register mem_rdata_i and pulse the owner's rvalidN_o with errN_o=0 in the next cycle, and go to IDLE.
REQ-012 Writes SHALL also complete through rvalidN_o (rdata don't-care); a write SHALL never complete without a response.
REQ-013 WAIT_RSP SHALL run an 8-bit cycle counter cleared on entry; if it reaches TIMEOUT-1 with no mem_rvalid_i, the block SHALL pulse the owner's rvalidN_o with errN_o=1 and rdataN_o=0 next cycle and go to IDLE.
REQ-014 If mem_rvalid_i and the timeout occur in the same cycle, the data completion SHALL win (errN_o=0).
REQ-015 gntN_o SHALL be 0 outside IDLE; a request presented while busy SHALL wait, held by the requester, until the FSM returns to IDLE.
REQ-016 Request inputs SHALL have no effect after capture; deasserting reqN_i during ISSUE/WAIT_RSP SHALL not cancel the transaction.
REQ-017 Only the owner's rvalidN_o SHALL pulse; the other port's rvalid/err SHALL stay 0 and its rdata SHALL hold.
REQ-018 Minimum read latency, from gnt cycle to rvalid cycle, SHALL be 3 cycles with mem_gnt_i and mem_rvalid_i each arriving in the first cycle of their state; back-to-back grants SHALL be at least 4 cycles apart.

Reset
REQ-019 On rst_ni=0 the FSM SHALL go to IDLE asynchronously and the pointer to port 0; all outputs, captured registers and the counter SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abort it with no rvalid pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-021 Port 0 reads addr 0x010 alone; the SRAM grants immediately and returns 0xDEADBEEF one cycle later -> gnt0_o at T, mem_req_o at T+1, rvalid0_o=1 with rdata0_o=0xDEADBEEF and err0_o=0 at T+3.
REQ-022 Both ports request continuously from reset -> grants alternate 0,1,0,1; no port is granted twice in a row.
REQ-023 Port 1 writes 0xA5A5A5A5 with be=4'b0011 -> mem_we_o=1 and mem_be_o=4'b0011 held through ISSUE until mem_gnt_i; rvalid1_o pulses once.
REQ-024 TIMEOUT=4 and mem_rvalid_i never asserts -> rvalid0_o=1 with err0_o=1 and rdata0_o=0, 4 cycles after WAIT_RSP entry; then port 1 is served.
REQ-025 mem_gnt_i held low for 5 cycles during ISSUE -> all mem_* fields stay constant; rst_ni pulsed low in WAIT_RSP -> all outputs 0 immediately and no rvalid pulse after release.
